// File: rtl/rv32_pkg.sv
// rv32_pkg: shared rv32 pipeline definitions used by the memory-access stage.
//   - ALU_OP_* operation codes (6 bits)
//   - mem_size_t / mem_state_t enums
//   - decode_mem_op(): alu_op -> access size and load signedness
package rv32_pkg;

    localparam logic [5:0] ALU_OP_ADD = 6'h00;
    localparam logic [5:0] ALU_OP_SUB = 6'h01;
    localparam logic [5:0] ALU_OP_AND = 6'h02;
    localparam logic [5:0] ALU_OP_OR  = 6'h03;
    localparam logic [5:0] ALU_OP_XOR = 6'h04;
    localparam logic [5:0] ALU_OP_SLL = 6'h05;
    localparam logic [5:0] ALU_OP_LB  = 6'h10;
    localparam logic [5:0] ALU_OP_LH  = 6'h11;
    localparam logic [5:0] ALU_OP_LW  = 6'h12;
    localparam logic [5:0] ALU_OP_LD  = 6'h13;
    localparam logic [5:0] ALU_OP_LBU = 6'h14;
    localparam logic [5:0] ALU_OP_LHU = 6'h15;
    localparam logic [5:0] ALU_OP_LWU = 6'h16;
    localparam logic [5:0] ALU_OP_SB  = 6'h18;
    localparam logic [5:0] ALU_OP_SH  = 6'h19;
    localparam logic [5:0] ALU_OP_SW  = 6'h1A;

    typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_t;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} mem_state_t;

    typedef struct packed {
        mem_size_t size;
        logic      is_signed;
    } mem_op_t;

    // Anything not explicitly byte/half (including LW/LWU/LD) is a
    // full-word access with no extension.
    function automatic mem_op_t decode_mem_op(input logic [5:0] op);
        mem_op_t r;
        r.size      = WORD;
        r.is_signed = 1'b0;
        case (op)
            ALU_OP_LB:  begin r.size = BYTE; r.is_signed = 1'b1; end
            ALU_OP_LBU: r.size = BYTE;
            ALU_OP_SB:  r.size = BYTE;
            ALU_OP_LH:  begin r.size = HALF; r.is_signed = 1'b1; end
            ALU_OP_LHU: r.size = HALF;
            ALU_OP_SH:  r.size = HALF;
            default:    ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// load_align: combinational load-data extraction.
//   rdata_i   - 32-bit word returned by data memory
//   addr_lo_i - byte offset within the word
//   size_i    - access size (BYTE/HALF/WORD)
//   signed_i  - 1 = sign-extend, 0 = zero-extend
//   data_o    - extended 32-bit value
module load_align
    import rv32_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  mem_size_t   size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            BYTE:    data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            HALF:    data_o = {{16{signed_i & half_sel[15]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: rv32 memory-access stage between execute and writeback.
// Non-memory results pass to writeback in one cycle; loads/stores run a
// req/gnt/rvalid transaction on the data-memory port.
// Ports:
//   clk, resetn (async active-low)
//   ex_*, alu_op, alu_result, store_data, rd_addr, *_enable : execute side
//   dmem_req/we/addr/be/wdata (out), dmem_gnt/rvalid/rdata (in) : memory
//   wb_valid/we/rd/data : writeback, misalign_err : misaligned-access pulse
// Optional feature: MEM_MISALIGN_TRAP_EN -- trap misaligned accesses instead
// of aligning them down to the access size.
module mem_access
    import rv32_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [5:0]        alu_op,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    input  logic [4:0]        rd_addr,
    input  logic              reg_write_enable,
    input  logic              mem_read_enable,
    input  logic              mem_write_enable,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              misalign_err
);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       wb_data_q;
    logic [4:0]        rd_q;
    logic              store_q, rwe_q, sign_q;
    mem_size_t         size_q;

    mem_op_t     dec;
    logic        is_mem, accept, trap;
    logic [31:0] ld_data;

    assign dec    = decode_mem_op(alu_op);
    assign is_mem = mem_read_enable | mem_write_enable;
    assign accept = ex_valid && (state_q == IDLE);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;
    always_comb begin
        case (dec.size)
            HALF:    trap = is_mem & alu_result[0];
            WORD:    trap = is_mem & (|alu_result[1:0]);
            default: trap = 1'b0;
        endcase
    end
    assign misalign_err = (state_q == RESP) & misalign_q;
`else
    assign trap         = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Address aligned down to the access size, then lane/byte-enable setup.
    // Write enable wins when both read and write are flagged.
    always_comb begin
        addr_d = alu_result[ADDR_W-1:0];
        case (dec.size)
            HALF:    addr_d[0]   = 1'b0;
            WORD:    addr_d[1:0] = 2'b00;
            default: ;
        endcase
        be_d    = 4'b1111;
        wdata_d = '0;
        if (mem_write_enable) begin
            case (dec.size)
                BYTE: begin
                    be_d    = 4'b0001 << addr_d[1:0];
                    wdata_d = {4{store_data[7:0]}};
                end
                HALF: begin
                    be_d    = addr_d[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{store_data[15:0]}};
                end
                default: wdata_d = store_data;
            endcase
        end
    end

    load_align u_load_align (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (addr_q[1:0]),
        .size_i    (size_q),
        .signed_i  (sign_q),
        .data_o    (ld_data)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ex_valid) state_d = (is_mem && !trap) ? REQ : RESP;
            REQ:     if (dmem_gnt) state_d = store_q ? RESP : WAIT;
            WAIT:    if (dmem_rvalid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ex_ready = (state_q == IDLE);
        dmem_req = (state_q == REQ);
        dmem_we  = (state_q == REQ) & store_q;
        wb_valid = (state_q == RESP);
        wb_we    = (state_q == RESP) & rwe_q & (rd_q != 5'd0);
    end

    assign dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign wb_rd      = rd_q;
    assign wb_data    = wb_data_q;

    // Transaction fields held stable from accept until the next accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
            rd_q      <= '0;
            store_q   <= 1'b0;
            rwe_q     <= 1'b0;
            sign_q    <= 1'b0;
            size_q    <= BYTE;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else if (accept) begin
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_addr;
            store_q   <= mem_write_enable;
            size_q    <= dec.size;
            sign_q    <= dec.is_signed;
            // Loads always write back; stores and trapped accesses never do.
            rwe_q     <= is_mem ? (!mem_write_enable && !trap) : reg_write_enable;
            wb_data_q <= is_mem ? 32'd0 : alu_result;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= trap;
`endif
        end else if (state_q == WAIT && dmem_rvalid) begin
            wb_data_q <= ld_data;
        end
    end

endmodule
